// File: rtl/pwm_pkg.sv
// Shared PWM definitions: sequencer states and default widths/values.
// Reused by the counter, period register and update controller.
package pwm_pkg;

   localparam int PWM_W = 12;

   localparam logic [PWM_W-1:0] PRD_RST = PWM_W'(1000);
   localparam logic [PWM_W-1:0] CMP_RST = '0;
   localparam logic [PWM_W-1:0] MIN_PRD = PWM_W'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } pwm_state_e;

endpackage

// File: rtl/pwm_update_ctrl_if.sv
// Host configuration handshake for the PWM update controller.
// The host drives valid/prd/cmp and the controller returns ready.
interface pwm_update_ctrl_if #(
   parameter int W = pwm_pkg::PWM_W
) ();

   logic         valid;
   logic         ready;
   logic [W-1:0] prd;
   logic [W-1:0] cmp;

   modport master (
      output valid,
      output prd,
      output cmp,
      input  ready
   );

   modport slave (
      input  valid,
      input  prd,
      input  cmp,
      output ready
   );

endinterface

// File: rtl/pwm_shadow_reg.sv
// Shadow period/compare holding register with legality check.
// Accepts one setting at a time; the top commits it at counter zero.
module pwm_shadow_reg #(
   parameter int           W       = pwm_pkg::PWM_W,
   parameter logic [W-1:0] MIN_PRD = pwm_pkg::MIN_PRD
) (
   input  logic          clk_i,
   input  logic          rst_i,
   pwm_update_ctrl_if.slave cfg,
   input  logic          direct_i,
   input  logic          commit_i,
   output logic          full_o,
   output logic          wr_o,
   output logic          err_o,
   output logic [W-1:0]  prd_o,
   output logic [W-1:0]  cmp_o
);

   logic         full_q, full_d;
   logic         err_q;
   logic [W-1:0] prd_q, prd_d;
   logic [W-1:0] cmp_q, cmp_d;
   logic         xfer;
   logic         legal;

   assign cfg.ready = !full_q && !rst_i;
   assign xfer      = cfg.valid && cfg.ready;
   assign legal     = (cfg.prd >= MIN_PRD) &&
                      (cfg.cmp <= cfg.prd);
   assign wr_o      = xfer && legal;

   // Commit and a new fill never coincide: ready is low while full.
   always_comb begin
      full_d = full_q;
      prd_d  = prd_q;
      cmp_d  = cmp_q;
      if (commit_i) begin
         full_d = 1'b0;
      end
      if (wr_o && !direct_i) begin
         full_d = 1'b1;
         prd_d  = cfg.prd;
         cmp_d  = cfg.cmp;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         err_q  <= 1'b0;
         prd_q  <= '0;
         cmp_q  <= '0;
      end else begin
         full_q <= full_d;
         err_q  <= xfer && !legal;
         prd_q  <= prd_d;
         cmp_q  <= cmp_d;
      end
   end

   assign full_o = full_q;
   assign err_o  = err_q;
   assign prd_o  = prd_q;
   assign cmp_o  = cmp_q;

endmodule

// File: rtl/pwm_update_ctrl.sv
// PWM sequencer: starts/stops the triangle counter and commits
// shadowed period/compare settings only at the counter zero point.
module pwm_update_ctrl #(
   parameter int           W       = pwm_pkg::PWM_W,
   parameter logic [W-1:0] PRD_RST = pwm_pkg::PRD_RST,
   parameter logic [W-1:0] CMP_RST = pwm_pkg::CMP_RST,
   parameter logic [W-1:0] MIN_PRD = pwm_pkg::MIN_PRD
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   pwm_update_ctrl_if.slave cfg,
   input  logic          ctr_zero_i,
   output logic          ctr_clk_en_o,
   output logic          ctr_rst_o,
   output logic          ctr_load_en_o,
   output logic [W-1:0]  ctr_load_o,
   output logic [W-1:0]  prd_out_o,
   output logic [W-1:0]  cmp_out_o,
   output logic          upd_done_o,
   output logic          cfg_err_o
);

   import pwm_pkg::*;

   pwm_state_e   state_q, state_d;
   logic         clk_en_q, rst_q, load_en_q, upd_q;
   logic [W-1:0] load_q;
   logic [W-1:0] prd_q, prd_d;
   logic [W-1:0] cmp_q, cmp_d;

   logic         sh_full, sh_wr, sh_err;
   logic [W-1:0] sh_prd, sh_cmp;
   logic         direct, commit, running;

   assign direct  = (state_q == IDLE);
   assign running = (state_q == RUN) || (state_q == STOP);
   assign commit  = running && ctr_zero_i && sh_full;

   pwm_shadow_reg #(
      .W       (W),
      .MIN_PRD (MIN_PRD)
   ) u_shadow (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .cfg      (cfg),
      .direct_i (direct),
      .commit_i (commit),
      .full_o   (sh_full),
      .wr_o     (sh_wr),
      .err_o    (sh_err),
      .prd_o    (sh_prd),
      .cmp_o    (sh_cmp)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (enable_i) state_d = START;
         START: state_d = RUN;
         RUN:   if (!enable_i) state_d = STOP;
         STOP: begin
            // Re-enable wins over zero: keep counting, no reset.
            if (enable_i)        state_d = RUN;
            else if (ctr_zero_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      prd_d = prd_q;
      cmp_d = cmp_q;
      if (direct && sh_wr) begin
         prd_d = cfg.prd;
         cmp_d = cfg.cmp;
      end else if (commit) begin
         prd_d = sh_prd;
         cmp_d = sh_cmp;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         clk_en_q  <= 1'b0;
         rst_q     <= 1'b1;
         load_en_q <= 1'b0;
         load_q    <= '0;
         prd_q     <= PRD_RST;
         cmp_q     <= CMP_RST;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_en_q  <= (state_d == RUN) ||
                      (state_d == STOP);
         rst_q     <= (state_d == IDLE);
         load_en_q <= (state_d == START);
         load_q    <= '0;
         prd_q     <= prd_d;
         cmp_q     <= cmp_d;
         upd_q     <= (direct && sh_wr) || commit;
      end
   end

   assign ctr_clk_en_o  = clk_en_q;
   assign ctr_rst_o     = rst_q;
   assign ctr_load_en_o = load_en_q;
   assign ctr_load_o    = load_q;
   assign prd_out_o     = prd_q;
   assign cmp_out_o     = cmp_q;
   assign upd_done_o    = upd_q;
   assign cfg_err_o     = sh_err;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed self-checking bench for pwm_update_ctrl.
// Counter zero is driven by hand; expectations are hand-computed.
module tb_pwm_update_ctrl;

   localparam int W = 12;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         ctr_zero;
   logic         ctr_clk_en;
   logic         ctr_rst;
   logic         ctr_load_en;
   logic [W-1:0] ctr_load;
   logic [W-1:0] prd_out;
   logic [W-1:0] cmp_out;
   logic         upd_done;
   logic         cfg_err;

   int checks = 0;
   int errors = 0;

   pwm_update_ctrl_if #(.W(W)) cfg_if ();

   pwm_update_ctrl #(
      .W       (W),
      .PRD_RST (12'd1000),
      .CMP_RST (12'd0),
      .MIN_PRD (12'd2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .cfg           (cfg_if.slave),
      .ctr_zero_i    (ctr_zero),
      .ctr_clk_en_o  (ctr_clk_en),
      .ctr_rst_o     (ctr_rst),
      .ctr_load_en_o (ctr_load_en),
      .ctr_load_o    (ctr_load),
      .prd_out_o     (prd_out),
      .cmp_out_o     (cmp_out),
      .upd_done_o    (upd_done),
      .cfg_err_o     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] p,
                       input logic [W-1:0] c);
      cfg_if.valid = 1'b1;
      cfg_if.prd   = p;
      cfg_if.cmp   = c;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_prd"},    prd_out,     1000);
      chk({tag, "_cmp"},    cmp_out,     0);
      chk({tag, "_crst"},   ctr_rst,     1);
      chk({tag, "_clken"},  ctr_clk_en,  0);
      chk({tag, "_lden"},   ctr_load_en, 0);
      chk({tag, "_load"},   ctr_load,    0);
      chk({tag, "_upd"},    upd_done,    0);
      chk({tag, "_err"},    cfg_err,     0);
   endtask

   initial begin
      rst          = 1'b1;
      enable       = 1'b0;
      ctr_zero     = 1'b0;
      cfg_if.valid = 1'b0;
      cfg_if.prd   = '0;
      cfg_if.cmp   = '0;
      step();
      step();
      chk("rst_ready", cfg_if.ready, 0);
      chk_reset_outs("rst");

      rst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_upd", upd_done, 0);
         chk("idle_err", cfg_err, 0);
      end
      chk("idle_prd", prd_out, 1000);
      chk("idle_cmp", cmp_out, 0);
      chk("idle_crst", ctr_rst, 1);
      chk("idle_ready", cfg_if.ready, 1);

      // direct write in IDLE
      send(12'd800, 12'd200);
      step();
      cfg_if.valid = 1'b0;
      chk("dir_prd", prd_out, 800);
      chk("dir_cmp", cmp_out, 200);
      chk("dir_upd", upd_done, 1);
      chk("dir_ready", cfg_if.ready, 1);
      step();
      chk("dir_upd_off", upd_done, 0);

      // start sequence
      enable = 1'b1;
      step();
      chk("start_lden", ctr_load_en, 1);
      chk("start_crst", ctr_rst, 0);
      chk("start_clken", ctr_clk_en, 0);
      chk("start_load", ctr_load, 0);
      step();
      chk("run_clken", ctr_clk_en, 1);
      chk("run_lden", ctr_load_en, 0);
      chk("run_crst", ctr_rst, 0);

      // shadow fill in RUN, commit at zero
      send(12'd1000, 12'd500);
      step();
      cfg_if.valid = 1'b0;
      chk("sh_ready", cfg_if.ready, 0);
      chk("sh_cmp_hold", cmp_out, 200);
      chk("sh_upd", upd_done, 0);
      step();
      step();
      chk("sh_ready2", cfg_if.ready, 0);
      chk("sh_cmp_hold2", cmp_out, 200);
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("cm_prd", prd_out, 1000);
      chk("cm_cmp", cmp_out, 500);
      chk("cm_upd", upd_done, 1);
      chk("cm_ready", cfg_if.ready, 1);
      step();
      chk("cm_upd_off", upd_done, 0);

      // illegal: cmp > prd
      send(12'd100, 12'd150);
      step();
      cfg_if.valid = 1'b0;
      chk("il1_err", cfg_err, 1);
      chk("il1_upd", upd_done, 0);
      chk("il1_ready", cfg_if.ready, 1);
      step();
      chk("il1_err_off", cfg_err, 0);

      // illegal: prd below minimum
      send(12'd1, 12'd0);
      step();
      cfg_if.valid = 1'b0;
      chk("il2_err", cfg_err, 1);
      chk("il2_ready", cfg_if.ready, 1);
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("il2_err_off", cfg_err, 0);
      chk("il2_prd", prd_out, 1000);
      chk("il2_cmp", cmp_out, 500);
      chk("il2_upd", upd_done, 0);

      // boundary legal: prd = MIN_PRD, cmp = prd
      send(12'd2, 12'd2);
      step();
      cfg_if.valid = 1'b0;
      chk("bd_err", cfg_err, 0);
      chk("bd_ready", cfg_if.ready, 0);
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("bd_prd", prd_out, 2);
      chk("bd_cmp", cmp_out, 2);
      chk("bd_upd", upd_done, 1);

      // transfer coincident with zero
      send(12'd600, 12'd300);
      ctr_zero = 1'b1;
      step();
      cfg_if.valid = 1'b0;
      ctr_zero     = 1'b0;
      chk("sz_prd_hold", prd_out, 2);
      chk("sz_upd", upd_done, 0);
      chk("sz_ready", cfg_if.ready, 0);
      step();
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("sz_prd", prd_out, 600);
      chk("sz_cmp", cmp_out, 300);
      chk("sz_upd2", upd_done, 1);

      // enable toggle inside STOP
      enable = 1'b0;
      step();
      chk("stop_clken", ctr_clk_en, 1);
      chk("stop_crst", ctr_rst, 0);
      enable = 1'b1;
      step();
      chk("rerun_clken", ctr_clk_en, 1);
      chk("rerun_crst", ctr_rst, 0);
      chk("rerun_lden", ctr_load_en, 0);

      // STOP then zero returns to IDLE
      enable = 1'b0;
      step();
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("toidle_crst", ctr_rst, 1);
      chk("toidle_clken", ctr_clk_en, 0);

      // restart, pend a shadow, stop, then reset
      enable = 1'b1;
      step();
      chk("re_lden", ctr_load_en, 1);
      step();
      send(12'd400, 12'd100);
      step();
      cfg_if.valid = 1'b0;
      chk("pend_ready", cfg_if.ready, 0);
      enable = 1'b0;
      step();
      chk("pend_clken", ctr_clk_en, 1);
      rst = 1'b1;
      step();
      chk("mr_ready", cfg_if.ready, 0);
      chk_reset_outs("mr");
      rst = 1'b0;
      #1;
      chk("mr_ready_rel", cfg_if.ready, 1);
      ctr_zero = 1'b1;
      step();
      ctr_zero = 1'b0;
      chk("mr_prd", prd_out, 1000);
      chk("mr_cmp", cmp_out, 0);
      chk("mr_upd", upd_done, 0);
      chk("mr_crst", ctr_rst, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
